// File: rtl/cdc_pkg.sv
// Shared constants for the bus-crossing launcher: state encodings and
// legal parameter ranges.
package cdc_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] REQ     = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam int unsigned ACK_STAGES_MIN   = 2;
    localparam int unsigned ACK_STAGES_MAX   = 4;
    localparam int unsigned SETUP_CYCLES_MIN = 1;
    localparam int unsigned SETUP_CYCLES_MAX = 15;

endpackage

// File: rtl/cdc_bus_launcher_ack_sync.sv
// Single-bit multi-flop synchronizer for handshake lines returning from
// another clock domain; clears to 0 on synchronous reset.
module ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], D};
        end
    end

    assign Q = chain[STAGES-1];

endmodule

// File: rtl/cdc_bus_launcher.sv
// Source-domain launcher: captures a word, holds it on TX_DATA and runs a
// 4-phase req/ack handshake against a synchronized RX_ACK.
module cdc_bus_launcher
    import cdc_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned ACK_STAGES   = 2,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] SRC_DATA,
    input  logic                 SRC_VALID,
    output logic                 SRC_READY,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 TX_REQ,
    input  logic                 RX_ACK,
    output logic                 BUSY,
    output logic                 DONE
);

    generate
        if (ACK_STAGES < ACK_STAGES_MIN || ACK_STAGES > ACK_STAGES_MAX ||
            SETUP_CYCLES < SETUP_CYCLES_MIN || SETUP_CYCLES > SETUP_CYCLES_MAX) begin : g_bad_param
            $error("cdc_bus_launcher: ACK_STAGES or SETUP_CYCLES out of range");
        end
    endgenerate

    // Preloading SETUP_CYCLES (not minus one) keeps TX_REQ rising exactly
    // SETUP_CYCLES+1 edges after the accept edge.
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       ack_s;

    ack_sync #(.STAGES(ACK_STAGES)) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (RX_ACK),
        .Q   (ack_s)
    );

    assign SRC_READY = (state == IDLE) && !ack_s;
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            TX_DATA <= '0;
            TX_REQ  <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (SRC_VALID && SRC_READY) begin
                        TX_DATA <= SRC_DATA;
                        cnt     <= SETUP_LOAD;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        TX_REQ <= 1'b1;
                        state  <= REQ;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        TX_REQ <= 1'b0;
                        state  <= RELEASE;
                    end
                end
                default: begin
                    if (!ack_s) begin
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_bus_launcher.sv
// Directed bench for cdc_bus_launcher: cycle table plus back-to-back,
// hold-off and long-setup sequences.
module tb_cdc_bus_launcher;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SRC_DATA = 8'h00;
    logic       SRC_VALID = 1'b0;
    logic       SRC_READY;
    logic [7:0] TX_DATA;
    logic       TX_REQ;
    logic       RX_ACK = 1'b0;
    logic       BUSY;
    logic       DONE;

    logic [7:0] d4 = 8'h00;
    logic       v4 = 1'b0;
    logic       rdy4;
    logic [7:0] txd4;
    logic       req4;
    logic       ack4 = 1'b0;
    logic       busy4;
    logic       done4;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        auto_ack = 1'b0;

    always #5 CLK = ~CLK;

    cdc_bus_launcher #(.BUS_WIDTH(8), .ACK_STAGES(2), .SETUP_CYCLES(1)) dut (
        .CLK(CLK), .RST(RST), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
        .SRC_READY(SRC_READY), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ),
        .RX_ACK(RX_ACK), .BUSY(BUSY), .DONE(DONE)
    );

    cdc_bus_launcher #(.BUS_WIDTH(8), .ACK_STAGES(2), .SETUP_CYCLES(4)) dut4 (
        .CLK(CLK), .RST(RST), .SRC_DATA(d4), .SRC_VALID(v4),
        .SRC_READY(rdy4), .TX_DATA(txd4), .TX_REQ(req4),
        .RX_ACK(ack4), .BUSY(busy4), .DONE(done4)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       ack;
        logic       e_ready;
        logic [7:0] e_txd;
        logic       e_req;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t v(input logic rst, input logic valid, input logic [7:0] data,
                               input logic ack, input logic e_ready, input logic [7:0] e_txd,
                               input logic e_req, input logic e_busy, input logic e_done);
        vec_t r;
        r.rst = rst; r.valid = valid; r.data = data; r.ack = ack;
        r.e_ready = e_ready; r.e_txd = e_txd; r.e_req = e_req;
        r.e_busy = e_busy; r.e_done = e_done;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Destination model for the main instance: echoes TX_REQ back as RX_ACK.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (auto_ack) RX_ACK = TX_REQ;
    endtask

    initial begin
        int unsigned dones;
        bit          found;
        int unsigned n;

        //            rst val data  ack | rdy txd   req busy done
        tbl[0]  = v(1, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[1]  = v(0, 1, 8'hA5, 0, 0, 8'hA5, 0, 1, 0);
        tbl[2]  = v(0, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 0);
        tbl[3]  = v(0, 0, 8'h00, 0, 0, 8'hA5, 1, 1, 0);
        tbl[4]  = v(0, 0, 8'h00, 1, 0, 8'hA5, 1, 1, 0);
        tbl[5]  = v(0, 0, 8'h00, 1, 0, 8'hA5, 1, 1, 0);
        tbl[6]  = v(0, 0, 8'h00, 1, 0, 8'hA5, 0, 1, 0);
        tbl[7]  = v(0, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 0);
        tbl[8]  = v(0, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 0);
        tbl[9]  = v(0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 1);
        tbl[10] = v(0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 0);
        tbl[11] = v(0, 0, 8'h00, 1, 1, 8'hA5, 0, 0, 0);
        tbl[12] = v(0, 0, 8'h00, 1, 0, 8'hA5, 0, 0, 0);
        tbl[13] = v(0, 1, 8'h77, 1, 0, 8'hA5, 0, 0, 0);
        tbl[14] = v(0, 1, 8'h77, 0, 0, 8'hA5, 0, 0, 0);
        tbl[15] = v(0, 1, 8'h77, 0, 1, 8'hA5, 0, 0, 0);
        tbl[16] = v(0, 1, 8'h77, 0, 0, 8'h77, 0, 1, 0);
        tbl[17] = v(0, 0, 8'h00, 0, 0, 8'h77, 0, 1, 0);
        tbl[18] = v(0, 0, 8'h00, 0, 0, 8'h77, 1, 1, 0);
        tbl[19] = v(1, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[20] = v(0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);

        #2;
        for (int i = 0; i < 21; i++) begin
            RST = tbl[i].rst; SRC_VALID = tbl[i].valid;
            SRC_DATA = tbl[i].data; RX_ACK = tbl[i].ack;
            tick();
            chk($sformatf("row%0d ready", i), 32'(SRC_READY), 32'(tbl[i].e_ready));
            chk($sformatf("row%0d tx_data", i), 32'(TX_DATA), 32'(tbl[i].e_txd));
            chk($sformatf("row%0d tx_req", i), 32'(TX_REQ), 32'(tbl[i].e_req));
            chk($sformatf("row%0d busy", i), 32'(BUSY), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d done", i), 32'(DONE), 32'(tbl[i].e_done));
        end

        // Back-to-back with SRC_VALID held, then hold-off with toggling data.
        auto_ack = 1'b1;
        dones = 0;
        SRC_VALID = 1'b1; SRC_DATA = 8'h01;
        tick();
        chk("b2b first accept", 32'(TX_DATA), 32'h01);
        chk("b2b first busy", 32'(BUSY), 32'd1);
        SRC_DATA = 8'h02;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (DONE) begin
                found = 1'b1;
                dones++;
            end else begin
                chk("b2b data held", 32'(TX_DATA), 32'h01);
                chk("b2b ready low", 32'(SRC_READY), 32'd0);
            end
        end
        chk("b2b first done seen", 32'(found), 32'd1);
        chk("b2b ready in done cycle", 32'(SRC_READY), 32'd1);
        chk("b2b data in done cycle", 32'(TX_DATA), 32'h01);
        tick();
        chk("b2b second accept", 32'(TX_DATA), 32'h02);
        chk("b2b second busy", 32'(BUSY), 32'd1);
        chk("b2b done one cycle", 32'(DONE), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            SRC_DATA = c[0] ? 8'hFF : 8'h00;
            tick();
            if (DONE) begin
                found = 1'b1;
                dones++;
                SRC_VALID = 1'b0;
            end else begin
                chk("holdoff data", 32'(TX_DATA), 32'h02);
                chk("holdoff ready", 32'(SRC_READY), 32'd0);
                chk("holdoff busy", 32'(BUSY), 32'd1);
            end
        end
        chk("b2b second done seen", 32'(found), 32'd1);
        chk("holdoff data at done", 32'(TX_DATA), 32'h02);
        tick();
        chk("b2b idle after", 32'(BUSY), 32'd0);
        chk("b2b done dropped", 32'(DONE), 32'd0);
        chk("b2b no third accept", 32'(TX_DATA), 32'h02);
        chk("b2b done count", 32'(dones), 32'd2);
        auto_ack = 1'b0;

        // Long setup: TX_REQ rises exactly 5 edges after accept.
        d4 = 8'h3C; v4 = 1'b1;
        tick();
        chk("setup4 accept data", 32'(txd4), 32'h3C);
        chk("setup4 req at accept", 32'(req4), 32'd0);
        v4 = 1'b0; d4 = 8'hC3;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("setup4 req low e%0d", e), 32'(req4), 32'd0);
            chk($sformatf("setup4 data e%0d", e), 32'(txd4), 32'h3C);
        end
        tick();
        chk("setup4 req rise e5", 32'(req4), 32'd1);
        ack4 = 1'b1;
        n = 0; found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            tick();
            n++;
            if (!req4) found = 1'b1;
            chk("setup4 data in req", 32'(txd4), 32'h3C);
        end
        chk("setup4 req fall edges", 32'(n), 32'd3);
        ack4 = 1'b0;
        n = 0; found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            tick();
            n++;
            if (done4) found = 1'b1;
        end
        chk("setup4 done edges", 32'(n), 32'd3);
        chk("setup4 data at done", 32'(txd4), 32'h3C);
        tick();
        chk("setup4 done one cycle", 32'(done4), 32'd0);
        chk("setup4 idle", 32'(busy4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
